// File: rtl/exe_div_unit_pkg.sv
// Shared definitions for the EXE-stage iterative divider.
// State codes are plain constants so that older tools can read them.
package exe_div_unit_pkg;

  localparam int DIV_ITER = 32;

  typedef logic [1:0] DivStateType;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/exe_div_unit_div_step.sv
// One radix-2 restoring iteration: shift {rem, quot} left, then subtract the
// divisor from the partial remainder when it fits.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quot,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] next_rem,
  output logic [DATA_WIDTH-1:0] next_quot
);

  // The shifted remainder can need one extra bit before the compare.
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic                  fits;

  assign shifted   = {rem, quot[DATA_WIDTH-1]};
  assign fits      = (shifted >= {1'b0, divisor});
  assign diff      = shifted[DATA_WIDTH-1:0] - divisor;
  assign next_rem  = fits ? diff : shifted[DATA_WIDTH-1:0];
  assign next_quot = {quot[DATA_WIDTH-2:0], fits};

endmodule

// File: rtl/exe_div_unit.sv
// EXE-stage DIV/DIVU unit: magnitude restoring divide over DATA_WIDTH cycles,
// sign fix and divide-by-zero override applied when the last step completes.
module exe_div_unit
  import exe_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_ITER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EXE_DivStart,
  input  logic                  EXE_DivSigned,
  input  logic [DATA_WIDTH-1:0] EXE_ResultA,
  input  logic [DATA_WIDTH-1:0] EXE_ResultB,
  input  logic                  EXE_Flush,
  output logic                  EXE_DivBusy,
  output logic                  EXE_DivDone,
  output logic [DATA_WIDTH-1:0] EXE_DivQuot,
  output logic [DATA_WIDTH-1:0] EXE_DivRem
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  DivStateType           state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic                  quot_neg;
  logic                  rem_neg;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] quot_out;
  logic [DATA_WIDTH-1:0] rem_out;

  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_quot;
  logic [DATA_WIDTH-1:0] fix_quot;
  logic [DATA_WIDTH-1:0] fix_rem;
  logic                  a_neg;
  logic                  b_neg;

  assign a_neg = EXE_DivSigned && EXE_ResultA[DATA_WIDTH-1];
  assign b_neg = EXE_DivSigned && EXE_ResultB[DATA_WIDTH-1];
  assign a_mag = a_neg ? (-EXE_ResultA) : EXE_ResultA;
  assign b_mag = b_neg ? (-EXE_ResultB) : EXE_ResultB;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .next_rem  (step_rem),
    .next_quot (step_quot)
  );

  // Division by zero reports all-ones / original dividend regardless of sign.
  assign fix_quot = div_zero ? '1 : (quot_neg ? (-step_quot) : step_quot);
  assign fix_rem  = div_zero ? dividend_q : (rem_neg ? (-step_rem) : step_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      count      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      quot_neg   <= 1'b0;
      rem_neg    <= 1'b0;
      div_zero   <= 1'b0;
      quot_out   <= '0;
      rem_out    <= '0;
    end else if (EXE_Flush) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      case (state)
        DIV_RUN: begin
          rem_q  <= step_rem;
          quot_q <= step_quot;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            state    <= DIV_DONE;
            quot_out <= fix_quot;
            rem_out  <= fix_rem;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (EXE_DivStart) begin
            state      <= DIV_RUN;
            count      <= CW'(DATA_WIDTH);
            rem_q      <= '0;
            quot_q     <= a_mag;
            divisor_q  <= b_mag;
            dividend_q <= EXE_ResultA;
            quot_neg   <= a_neg ^ b_neg;
            rem_neg    <= a_neg;
            div_zero   <= (EXE_ResultB == '0);
          end else begin
            state <= DIV_IDLE;
          end
        end
      endcase
    end
  end

  assign EXE_DivBusy = ((state == DIV_IDLE) && EXE_DivStart) ||
                       (state == DIV_RUN) ||
                       ((state == DIV_DONE) && EXE_DivStart);
  assign EXE_DivDone = (state == DIV_DONE) && !EXE_Flush;
  assign EXE_DivQuot = quot_out;
  assign EXE_DivRem  = rem_out;

endmodule

// File: tb/tb_exe_div_unit.sv
// Bench for exe_div_unit: directed cases with literal results plus random
// per-cycle stimulus checked against an arithmetic reference model.
module tb_exe_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  exe_div_unit #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .EXE_DivStart  (start),
    .EXE_DivSigned (sgn),
    .EXE_ResultA   (a),
    .EXE_ResultB   (b),
    .EXE_Flush     (flush),
    .EXE_DivBusy   (busy),
    .EXE_DivDone   (done),
    .EXE_DivQuot   (quot),
    .EXE_DivRem    (rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {quot, rem} from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (y == 32'd0) return {32'hFFFF_FFFF, x};
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      q  = sx / sy;
      r  = sx % sy;
      return {q[31:0], r[31:0]};
    end
    return {x / y, x % y};
  endfunction

  // Cycle-level model: an accepted op reports its result 33 cycles later.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= m_pq;
          m_r    <= m_pr;
        end
      end else if (start) begin
        {m_pq, m_pr} <= ref_div(sgn, a, b);
        m_left       <= 32;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, (m_left > 0) || start});
      check("done", {31'd0, done}, {31'd0, m_done && !flush});
      check("quot", quot, m_q);
      check("rem",  rem,  m_r);
    end
  end

  task automatic run_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er, input string name);
    int lat;
    @(posedge clk); #2;
    start = 1'b1; sgn = s; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    forever begin
      @(negedge clk);
      if (done || lat > 40) break;
      lat++;
    end
    check({name, "_latency"}, lat, 33);
    check({name, "_quot"}, quot, eq);
    check({name, "_rem"}, rem, er);
    check({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [63:0] res;
    int cnt, bl, dn;

    res = ref_div(1'b0, 32'd100, 32'd7);
    check("model_100_7", res[63:32], 32'd14);
    check("model_100_7_r", res[31:0], 32'd2);
    res = ref_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    check("model_m7_2", res[63:32], 32'hFFFF_FFFD);
    check("model_m7_2_r", res[31:0], 32'hFFFF_FFFF);
    res = ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("model_min_m1", res[63:32], 32'h8000_0000);
    check("model_min_m1_r", res[31:0], 32'd0);
    res = ref_div(1'b1, 32'hFFFF_FFFB, 32'd0);
    check("model_m5_0_r", res[31:0], 32'hFFFF_FFFB);

    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_quot", quot, 32'd0);
    check("reset_rem", rem, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_min_m1");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "divu_max_1");
    run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "divu_5_0");
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div_m5_0");

    // Flush at cycle 10 of an op; previous results must survive.
    @(posedge clk); #2;
    start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("flush_no_done", cnt, 0);
    check("flush_quot_kept", quot, 32'hFFFF_FFFF);
    check("flush_rem_kept", rem, 32'hFFFF_FFFB);

    // Reset at cycle 20 of an op clears everything.
    @(posedge clk); #2;
    start = 1'b1; sgn = 1'b0; a = 32'd50; b = 32'd5;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_quot", quot, 32'd0);
    check("rst_rem", rem, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // Back-to-back: second start held in the done cycle of the first.
    @(posedge clk); #2;
    start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #2 start = 1'b1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_quot1", quot, 32'd14);
    check("b2b_rem1", rem, 32'd2);
    check("b2b_busy_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #2;
    start = 1'b0;
    bl = 0; dn = 0;
    for (int k = 34; k <= 65; k++) begin
      @(negedge clk);
      if (!busy) bl++;
      if (done) dn++;
    end
    check("b2b_busy_gaps", bl, 0);
    check("b2b_early_done", dn, 0);
    @(negedge clk);
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_quot2", quot, 32'd3);
    check("b2b_rem2", rem, 32'd0);

    // Random per-cycle stimulus, checked only by the model compare.
    repeat (3000) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 5) == 0);
      sgn   = $urandom_range(0, 1);
      flush = ($urandom_range(0, 79) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 200);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        3: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
    end
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
